// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the register-file/ALU datapath: buffers 16-bit words
// in a FIFO and issues registered controls. Optional counters: DATAPATH_SEQ_PERF_EN.
module datapath_sequencer #(
  parameter int DEPTH = 4,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] instr_i,
  input  logic          instr_valid_i,
  output logic          instr_ready_o,
  input  logic          Flag,
  output logic          Wen,
  output logic [3:0]    WA,
  output logic [3:0]    Sel,
  output logic [3:0]    RAA,
  output logic [3:0]    RAB,
  output logic [2:0]    Op,
  output logic          issue_o,
  output logic          busy_o,
  output logic [2:0]    state_o
`ifdef DATAPATH_SEQ_PERF_EN
  ,
  output logic [15:0]   issued_cnt_o,
  output logic [15:0]   skipped_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_STALL   = 3'd2,
    S_FLAGCHK = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  localparam logic [1:0] K_LOAD  = 2'b00;
  localparam logic [1:0] K_ALU   = 2'b01;
  localparam logic [1:0] K_SKIPF = 2'b10;
  localparam logic [1:0] K_WAIT  = 2'b11;

  // Handshake: a word is transferred on a rising edge where instr_valid_i and
  // instr_ready_o are both high; instr_i must be held while valid && !ready.
  logic [IW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, count, occ_keep, occ_pop;
  logic          full, empty, push, pop;
  logic [IW-1:0] head;

  state_t        state, state_nxt;
  logic [7:0]    wait_cnt;
  logic          do_issue, do_load, do_alu, do_discard, wait_load, wait_dec;

  assign count         = wr_ptr - rd_ptr;
  assign full          = (count == (AW+1)'(DEPTH));
  assign empty         = (count == '0);
  assign instr_ready_o = !full;
  assign push          = instr_valid_i && !full;
  assign head          = mem[rd_ptr[AW-1:0]];
  // Occupancy after this edge, without and with a pop of the head.
  assign occ_keep      = count + (AW+1)'(push);
  assign occ_pop       = occ_keep - (AW+1)'(1);
  assign busy_o        = !empty || (state != S_IDLE);
  assign state_o       = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= instr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    do_issue   = 1'b0;
    do_load    = 1'b0;
    do_alu     = 1'b0;
    do_discard = 1'b0;
    wait_load  = 1'b0;
    wait_dec   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (empty) begin
          state_nxt = S_IDLE;
        end else begin
          pop       = 1'b1;
          do_issue  = 1'b1;
          state_nxt = (occ_pop != '0) ? S_ISSUE : S_IDLE;
          unique case (head[15:14])
            K_LOAD:  do_load = 1'b1;
            K_ALU:   do_alu  = 1'b1;
            K_SKIPF: state_nxt = S_FLAGCHK;
            K_WAIT: begin
              wait_load = 1'b1;
              if (head[7:0] != 8'd0) state_nxt = S_STALL;
            end
            default: ;
          endcase
        end
      end
      S_STALL: begin
        // Counter is never zero here; leaving on the 1->0 step gives n extra cycles.
        wait_dec = 1'b1;
        if (wait_cnt == 8'd1) state_nxt = (occ_keep != '0) ? S_ISSUE : S_IDLE;
      end
      S_FLAGCHK: begin
        if (Flag) state_nxt = S_DISCARD;
        else      state_nxt = (occ_keep != '0) ? S_ISSUE : S_IDLE;
      end
      S_DISCARD: begin
        if (!empty) begin
          pop        = 1'b1;
          do_discard = 1'b1;
          state_nxt  = (occ_pop != '0) ? S_ISSUE : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Wen      <= 1'b0;
      WA       <= '0;
      Sel      <= '0;
      RAA      <= '0;
      RAB      <= '0;
      Op       <= 3'b000;
      issue_o  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      Wen     <= do_load;
      issue_o <= do_issue;
      if (do_load) begin
        WA  <= head[11:8];
        Sel <= head[3:0];
      end
      if (do_alu) begin
        Op  <= head[13:11];
        RAA <= head[7:4];
        RAB <= head[3:0];
      end
      if (wait_load)     wait_cnt <= head[7:0];
      else if (wait_dec) wait_cnt <= wait_cnt - 8'd1;
    end
  end

`ifdef DATAPATH_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt_o  <= '0;
      skipped_cnt_o <= '0;
    end else begin
      if (do_issue && issued_cnt_o != 16'hFFFF)    issued_cnt_o  <= issued_cnt_o + 16'd1;
      if (do_discard && skipped_cnt_o != 16'hFFFF) skipped_cnt_o <= skipped_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed timing checks plus a
// scoreboard of expected output snapshots for every issued instruction.
module tb_datapath_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic        Flag = 1'b0;
  logic        Wen;
  logic [3:0]  WA, Sel, RAA, RAB;
  logic [2:0]  Op;
  logic        issue_o, busy_o;
  logic [2:0]  state_o;
`ifdef DATAPATH_SEQ_PERF_EN
  logic [15:0] issued_cnt_o, skipped_cnt_o;
`endif

  datapath_sequencer #(.DEPTH(DEPTH), .IW(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .Flag(Flag), .Wen(Wen), .WA(WA), .Sel(Sel),
    .RAA(RAA), .RAB(RAB), .Op(Op), .issue_o(issue_o), .busy_o(busy_o),
    .state_o(state_o)
`ifdef DATAPATH_SEQ_PERF_EN
    , .issued_cnt_o(issued_cnt_o), .skipped_cnt_o(skipped_cnt_o)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];
  int n_cmp = 0, n_err = 0;
  int accepted = 0, issue_cnt = 0, wen_cnt = 0;
  logic [3:0] m_wa = '0, m_sel = '0, m_raa = '0, m_rab = '0;
  logic [2:0] m_op = '0;
  logic       m_skip = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wa = '0; m_sel = '0; m_raa = '0; m_rab = '0; m_op = '0; m_skip = 1'b0;
    exp_q.delete();
  endtask

  // Applies one accepted word to the reference model in program order.
  task automatic model_push(input logic [15:0] w);
    logic wen;
    if (m_skip) begin
      m_skip = 1'b0;
      return;
    end
    wen = 1'b0;
    case (w[15:14])
      2'b00: begin m_wa = w[11:8]; m_sel = w[3:0]; wen = 1'b1; end
      2'b01: begin m_op = w[13:11]; m_raa = w[7:4]; m_rab = w[3:0]; end
      2'b10: m_skip = Flag;
      default: ;
    endcase
    exp_q.push_back({wen, m_wa, m_sel, m_raa, m_rab, m_op});
  endtask

  always @(negedge clk) begin
    if (rst_n && issue_o) begin
      issue_cnt++;
      if (Wen) wen_cnt++;
      if (exp_q.size() == 0) check("issue_queue_nonempty", 32'(exp_q.size()), 1);
      else check("issue_outputs", {Wen, WA, Sel, RAA, RAB, Op}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic [15:0] w);
    int t = 0;
    instr_i = w;
    instr_valid_i = 1'b1;
    while (!instr_ready_o && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("send_timeout", t, 0);
    @(posedge clk);
    accepted++;
    model_push(w);
    @(negedge clk);
  endtask

  task automatic drop();
    instr_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (busy_o && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("drain_timeout", t, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    drop();
    Flag = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int gap, w0, i0, a0;
    logic wen_seen, seen_full;

    do_reset();
    check("rst_wen", Wen, 0);
    check("rst_addr", {WA, Sel, RAA, RAB}, 0);
    check("rst_op", Op, 0);
    check("rst_issue", issue_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", instr_ready_o, 1);

    // LOAD latency: accepted at k, visible after k+2, Wen pulse, fields hold.
    send(16'h0305); drop();
    @(negedge clk);
    check("lat_not_early", issue_o, 0);
    @(negedge clk);
    check("lat_load", {Wen, WA, Sel, issue_o}, {1'b1, 4'd3, 4'd5, 1'b1});
    @(negedge clk);
    check("lat_hold", {Wen, WA, Sel, issue_o}, {1'b0, 4'd3, 4'd5, 1'b0});

    // ALU then LOAD issue on consecutive cycles.
    send(16'h4812); send(16'h0A07); drop();
    gap = 0;
    while (!issue_o && gap < 50) begin @(negedge clk); gap++; end
    check("b2b_alu", {Wen, Op, RAA, RAB}, {1'b0, 3'b001, 4'd1, 4'd2});
    @(negedge clk);
    check("b2b_load", {issue_o, Wen, WA, Sel}, {1'b1, 1'b1, 4'd10, 4'd7});
    drain();

    // WAIT 3 then ALU: ALU issues 4 cycles after WAIT issue, no Wen.
    send(16'hC003); send(16'h4000); drop();
    gap = 0;
    while (!issue_o && gap < 50) begin @(negedge clk); gap++; end
    wen_seen = Wen;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      wen_seen |= Wen;
    end while (!issue_o && gap < 50);
    check("wait_gap", gap, 4);
    check("wait_no_wen", wen_seen, 0);
    check("wait_alu_fields", {Op, RAA, RAB}, 0);
    drain();

    // SKIPF with Flag=1 drops the first LOAD.
    Flag = 1'b1; w0 = wen_cnt;
    send(16'h8000); send(16'h0101); send(16'h0202); drop();
    drain();
    check("skip1_wen_count", wen_cnt - w0, 1);
    check("skip1_wa", {WA, Sel}, {4'd2, 4'd2});
    Flag = 1'b0;

    // SKIPF with Flag=0 keeps both loads.
    w0 = wen_cnt;
    send(16'h8000); send(16'h0101); send(16'h0202); drop();
    drain();
    check("skip0_wen_count", wen_cnt - w0, 2);
    check("skip0_wa", WA, 2);

    // SKIPF on an empty FIFO waits in DISCARD for the next word.
    Flag = 1'b1; w0 = wen_cnt;
    send(16'h8000); drop();
    repeat (6) @(negedge clk);
    check("skip_empty_busy", busy_o, 1);
    check("skip_empty_state", state_o, 3'd4);
    send(16'h0707); send(16'h0303); drop();
    drain();
    check("skip_empty_wen_count", wen_cnt - w0, 1);
    check("skip_empty_wa", {WA, Sel}, {4'd3, 4'd3});
    Flag = 1'b0;

    // Continuous WAIT words fill the FIFO; ready drops at DEPTH occupancy.
    a0 = accepted; i0 = issue_cnt; seen_full = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      int t = 0;
      instr_i = 16'hC00A;
      instr_valid_i = 1'b1;
      while (!instr_ready_o && t < 300) begin
        if (!seen_full) begin
          seen_full = 1'b1;
          check("full_occupancy", (accepted - a0) - (issue_cnt - i0), DEPTH);
        end
        @(negedge clk);
        t++;
      end
      if (t >= 300) check("full_send_timeout", t, 0);
      @(posedge clk);
      accepted++;
      model_push(16'hC00A);
      @(negedge clk);
    end
    drop();
    drain();
    check("full_ready_dropped", seen_full, 1);
    check("full_issue_count", issue_cnt - i0, DEPTH + 2);

    // Random LOAD/ALU/short WAIT stream, back to back.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] w;
      w = 16'($urandom_range(0, 16'hFFFF));
      case ($urandom_range(0, 4))
        0, 1:    w[15:14] = 2'b00;
        2, 3:    w[15:14] = 2'b01;
        default: begin w[15:14] = 2'b11; w[7:0] = 8'($urandom_range(0, 2)); end
      endcase
      send(w);
      if ($urandom_range(0, 3) == 0) begin drop(); @(negedge clk); end
    end
    drop();
    drain();
    check("rand_queue_empty", exp_q.size(), 0);

    // Reset during STALL with 3 entries queued.
    send(16'hC00A); send(16'h0111); send(16'h0222); send(16'h0333); drop();
    repeat (2) @(negedge clk);
    check("pre_rst_stall", state_o, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {Wen, WA, Sel, RAA, RAB, Op, issue_o}, 0);
    check("midrst_busy_ready", {busy_o, instr_ready_o}, {1'b0, 1'b1});
    model_reset();
    i0 = issue_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("postrst_busy", busy_o, 0);
    check("postrst_no_issue", issue_cnt - i0, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Upstream control stage for the register-file/ALU datapath.
- Accepts 16-bit instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Decodes and issues them one per cycle as registered datapath controls: Wen, WA, Sel, RAA, RAB, Op.
- Supports timed waits and a Flag-conditional skip of the next instruction.

Parameters:
- DEPTH, 4, instruction FIFO depth; power of 2, at least 2.
- IW, 16, instruction width; fixed at 16, other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- instr_i  in  16  instruction word.
- instr_valid_i  in  1  instr_i valid.
- instr_ready_o  out  1  FIFO can accept; equals !full.
- Flag  in  1  datapath ALU flag.
- Wen  out  1  register write enable, 1-cycle pulse.
- WA  out  4  write address.
- Sel  out  4  InPort lane select.
- RAA  out  4  read address A.
- RAB  out  4  read address B.
- Op  out  3  ALU operation.
- issue_o  out  1  pulse: an instruction was issued this cycle.
- busy_o  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset values: Wen=0, WA=Sel=RAA=RAB=0, Op=3'b000, issue_o=0, busy_o=0, instr_ready_o=1; FIFO empty; FSM in IDLE; wait counter 0.
- Reset mid-operation: FIFO flushed, in-flight WAIT or SKIP abandoned, outputs return to reset values asynchronously.
- Instruction format, kind = [15:14]:
  - 00 LOAD: Wen=1, WA=[11:8], Sel=[3:0].
  - 01 ALU: Wen=0, Op=[13:11], RAA=[7:4], RAB=[3:0].
  - 10 SKIPF: skip the next instruction if Flag=1.
  - 11 WAIT: stall n=[7:0] extra cycles.
- Handshake: push when instr_valid_i && instr_ready_o. instr_i must stay stable while valid && !ready.
- Latency: a word accepted at edge k drives outputs from edge k+2, provided the FIFO was empty and the FSM was in IDLE.
- Throughput: back-to-back LOAD/ALU words issue one per cycle.
- Output hold rules:
  - Wen and issue_o are 1-cycle pulses.
  - WA, Sel, RAA, RAB, Op hold their last issued value when no issue occurs.
  - LOAD updates WA and Sel only.
  - ALU updates Op, RAA, RAB only.
- FSM states:
  - IDLE: FIFO empty. Go to ISSUE when the FIFO becomes non-empty.
  - ISSUE: pop the head and decode it.
    - LOAD/ALU: drive outputs; stay in ISSUE if more entries remain, else go to IDLE.
    - WAIT: issue_o=1, load counter with n. If n=0, act as a NOP; otherwise go to STALL.
    - SKIPF: issue_o=1, go to FLAGCHK.
  - STALL: decrement the counter each cycle, no pops; when it reaches 0, go to ISSUE or IDLE.
  - FLAGCHK: one settle cycle, then sample Flag.
    - Flag=0: go to ISSUE or IDLE.
    - Flag=1: go to DISCARD.
  - DISCARD: pop the next entry without issuing it (no output change, issue_o=0), then go to ISSUE or IDLE. If the FIFO is empty, wait in DISCARD until an entry arrives.
- Skip chaining: SKIPF followed by SKIPF with Flag=1 discards the second SKIPF; no chained evaluation.
- FIFO:
  - Simultaneous push and pop when not full: both occur, occupancy unchanged.
  - Push at full is impossible because ready is low.
  - Pop at empty never occurs.
  - Pointers wrap modulo DEPTH; occupancy is tracked with an extra pointer bit.

Optional Feature:
- Macro DATAPATH_SEQ_PERF_EN.
- Defined: adds outputs issued_cnt_o[15:0] and skipped_cnt_o[15:0].
  - issued_cnt_o counts issue_o pulses; skipped_cnt_o counts discards.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: no such ports or logic exist; all other behaviour is identical.

Test Plan:
- Reset then LOAD 16'h0305 accepted at edge k -> at edge k+2: Wen=1, WA=3, Sel=5, issue_o=1; at k+3: Wen=0, WA and Sel still 3 and 5.
- ALU 16'h4812 followed by LOAD 16'h0A07, back-to-back -> consecutive cycles: Op=3'b001, RAA=1, RAB=2, then Wen=1, WA=10, Sel=7.
- WAIT 16'hC003 followed by ALU 16'h4000 -> ALU issues exactly 4 cycles after the WAIT issue; Wen=0 throughout.
- SKIPF, LOAD 16'h0101, LOAD 16'h0202 with Flag=1 -> only WA=2 is written.
  - Same sequence with Flag=0 -> both loads are written.
  - SKIPF with an empty FIFO and Flag=1 -> the next word to arrive is discarded.
- Hold instr_valid_i high with DEPTH+2 WAIT 16'hC00A words -> instr_ready_o deasserts at DEPTH occupancy; no word lost or duplicated; all entries issue in order.
- Assert rst_n=0 during STALL with the FIFO holding 3 entries -> outputs reset immediately; after release busy_o=0 and no stale entries issue.
